// File: rtl/stream_matrix_loader_cfg.sv
// stream_matrix_loader_cfg: loads one run-time-sized matrix from a data stream into an external memory write port
module stream_matrix_loader_cfg #(
  parameter int MAX_ROWS = 4,
  parameter int MAX_COLS = 5,
  parameter int WIDTH = 32,
  localparam int ROW_ADDR_WIDTH = MAX_ROWS > 1 ? $clog2(MAX_ROWS) : 1,
  localparam int COL_ADDR_WIDTH = MAX_COLS > 1 ? $clog2(MAX_COLS) : 1,
  localparam int ROW_CFG_WIDTH = $clog2(MAX_ROWS + 1),
  localparam int COL_CFG_WIDTH = $clog2(MAX_COLS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_CFG_WIDTH-1:0]  cfg_rows,
  input  logic [COL_CFG_WIDTH-1:0]  cfg_cols,
  input  logic                      cfg_col_major,
  output logic                      busy,
  output logic                      done,
  output logic                      finished_loading,
  output logic                      cfg_error,
  output logic                      ds_next_data,
  input  logic [WIDTH-1:0]          ds_out,
  input  logic                      ds_valid,
  input  logic                      write_stall,
  output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
  output logic [COL_ADDR_WIDTH-1:0] write_col_addr,
  output logic [WIDTH-1:0]          write_data,
  output logic                      write_ready
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  state_e state_q;
  logic [ROW_CFG_WIDTH-1:0] rows_q;
  logic [COL_CFG_WIDTH-1:0] cols_q;
  logic cm_q, done_q, fin_q, err_q, wr_q;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d, wr_row_q;
  logic [COL_ADDR_WIDTH-1:0] col_q, col_d, wr_col_q;
  logic [WIDTH-1:0] wr_data_q;
  logic last_row, last_col, accept, cfg_ok;
  always_comb begin
    last_row = ROW_CFG_WIDTH'(row_q) == rows_q - ROW_CFG_WIDTH'(1);
    last_col = COL_CFG_WIDTH'(col_q) == cols_q - COL_CFG_WIDTH'(1);
    accept = ds_valid & ds_next_data;
    cfg_ok = cfg_rows != '0 && cfg_rows <= ROW_CFG_WIDTH'(MAX_ROWS) &&
             cfg_cols != '0 && cfg_cols <= COL_CFG_WIDTH'(MAX_COLS);
    row_d = cm_q ? (last_row ? '0 : row_q + 1'b1) : (last_col ? row_q + 1'b1 : row_q);
    col_d = cm_q ? (last_row ? col_q + 1'b1 : col_q) : (last_col ? '0 : col_q + 1'b1);
  end
  assign ds_next_data = state_q == LOAD && !write_stall;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign finished_loading = fin_q;
  assign cfg_error = err_q;
  assign write_ready = wr_q;
  assign write_row_addr = wr_row_q;
  assign write_col_addr = wr_col_q;
  assign write_data = wr_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      cm_q      <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (cfg_ok) begin
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            cm_q    <= cfg_col_major;
            row_q   <= '0;
            col_q   <= '0;
            fin_q   <= 1'b0;
            state_q <= LOAD;
          end else err_q <= 1'b1;
        end
        LOAD: if (accept) begin
          wr_q      <= 1'b1;
          wr_row_q  <= row_q;
          wr_col_q  <= col_q;
          wr_data_q <= ds_out;
          row_q     <= row_d;
          col_q     <= col_d;
          // the final element's write issues alongside done and finished_loading
          if (last_row && last_col) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            fin_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_matrix_loader_cfg.sv
// tb_stream_matrix_loader_cfg: randomized stream loads checked every cycle against an index-arithmetic model
module tb_stream_matrix_loader_cfg;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_col_major = 1'b0;
  logic [2:0] cfg_rows = '0, cfg_cols = '0;
  logic busy, done, finished_loading, cfg_error, ds_next_data, write_ready;
  logic [W-1:0] ds_out = '0, write_data;
  logic ds_valid = 1'b0, write_stall = 1'b0;
  logic [1:0] write_row_addr;
  logic [2:0] write_col_addr;
  int tests = 0, fails = 0, err_cnt = 0;
  int m_state = 0, m_n = 0, m_rows = 1, m_cols = 1, e_r = 0, e_c = 0;
  bit m_cm = 0, m_fin = 0, e_wr = 0, e_done = 0, e_err = 0;
  logic [W-1:0] e_d = '0;
  typedef struct {int r; int c; logic [W-1:0] d;} wr_t;
  wr_t wlog[$];

  stream_matrix_loader_cfg #(.MAX_ROWS(4), .MAX_COLS(5), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_col_major(cfg_col_major), .busy(busy), .done(done),
    .finished_loading(finished_loading), .cfg_error(cfg_error),
    .ds_next_data(ds_next_data), .ds_out(ds_out), .ds_valid(ds_valid),
    .write_stall(write_stall), .write_row_addr(write_row_addr),
    .write_col_addr(write_col_addr), .write_data(write_data), .write_ready(write_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input int i, input int r, input int c);
    if (i < wlog.size()) begin
      chk({name, "_row"}, 64'(wlog[i].r), 64'(r));
      chk({name, "_col"}, 64'(wlog[i].c), 64'(c));
    end else chk({name, "_missing"}, 64'(wlog.size()), 64'(i + 1));
  endtask

  // mid-cycle: compare against the model, then advance it with the inputs the next edge will see
  always @(negedge clk) begin
    chk("busy", busy, 64'(m_state != 0));
    chk("done", done, e_done);
    chk("finished_loading", finished_loading, m_fin);
    chk("cfg_error", cfg_error, e_err);
    chk("write_ready", write_ready, e_wr);
    chk("write_row_addr", write_row_addr, 64'(e_r));
    chk("write_col_addr", write_col_addr, 64'(e_c));
    chk("write_data", write_data, e_d);
    chk("ds_next_data", ds_next_data, 64'(m_state == 1 && !write_stall));
    if (write_ready) wlog.push_back('{int'(write_row_addr), int'(write_col_addr), write_data});
    if (cfg_error) err_cnt++;
    e_wr = 0; e_done = 0; e_err = 0;
    if (rst) begin
      m_state = 0; m_n = 0; m_fin = 0; e_r = 0; e_c = 0; e_d = '0;
    end else if (m_state == 0) begin
      if (start) begin
        if (cfg_rows >= 1 && cfg_rows <= 4 && cfg_cols >= 1 && cfg_cols <= 5) begin
          m_rows = int'(cfg_rows); m_cols = int'(cfg_cols); m_cm = cfg_col_major;
          m_n = 0; m_fin = 0; m_state = 1;
        end else e_err = 1;
      end
    end else if (m_state == 1) begin
      if (ds_valid && !write_stall) begin
        e_wr = 1;
        e_r = m_cm ? m_n % m_rows : m_n / m_cols;
        e_c = m_cm ? m_n / m_rows : m_n % m_cols;
        e_d = ds_out;
        m_n++;
        if (m_n == m_rows * m_cols) begin
          m_state = 2; e_done = 1; m_fin = 1;
        end
      end
    end else m_state = 0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] r, input logic [2:0] c, input logic cm);
    wlog.delete();
    cfg_rows = r; cfg_cols = c; cfg_col_major = cm; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, data = element index; 1: valid alternates, stall every third cycle; 2: random
  task automatic run(input int mode, input int start_at, input int rst_at);
    int cyc = 0;
    bit st = 0, rs = 0, fin = 0;
    while (cyc < 300 && !fin) begin
      start = (m_n == start_at && !st);
      if (start) begin st = 1; cfg_rows = 3'd1; cfg_cols = 3'd1; end
      rst = (m_n == rst_at && !rs);
      if (rst) rs = 1;
      if (mode == 0) begin
        ds_valid = 1'b1; write_stall = 1'b0; ds_out = W'(m_n);
      end else if (mode == 1) begin
        ds_valid = cyc % 2 == 0; write_stall = cyc % 3 == 2; ds_out = $urandom;
      end else begin
        ds_valid = $urandom % 4 != 0; write_stall = $urandom % 4 == 0; ds_out = $urandom;
      end
      tick;
      cyc++;
      fin = m_state == 0;
    end
    if (!fin) chk("load_timeout", 64'(cyc), 64'(0));
    start = 1'b0; rst = 1'b0; ds_valid = 1'b0; write_stall = 1'b0;
  endtask

  initial begin
    int e0, r, c;
    repeat (2) tick;
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_write_ready", write_ready, 0);
    chk("reset_ds_next_data", ds_next_data, 0);
    chk("reset_finished", finished_loading, 0);
    do_start(3'd3, 3'd4, 1'b0);
    run(0, -1, -1);
    chk("t1_count", 64'(wlog.size()), 12);
    chk_w("t1_w5", 5, 1, 1);
    chk_w("t1_w11", 11, 2, 3);
    if (wlog.size() > 5) chk("t1_w5_data", wlog[5].d, 5);
    chk("t1_finished", finished_loading, 1);
    do_start(3'd3, 3'd4, 1'b1);
    run(0, -1, -1);
    chk("t2_count", 64'(wlog.size()), 12);
    chk_w("t2_w5", 5, 2, 1);
    chk_w("t2_w11", 11, 2, 3);
    chk("t2_next_data", ds_next_data, 0);
    do_start(3'd4, 3'd5, 1'b0);
    run(1, -1, -1);
    chk("t3_count", 64'(wlog.size()), 20);
    chk_w("t3_w7", 7, 1, 2);
    chk_w("t3_w19", 19, 3, 4);
    e0 = err_cnt;
    do_start(3'd0, 3'd4, 1'b0);
    repeat (2) tick;
    do_start(3'd3, 3'd6, 1'b0);
    repeat (2) tick;
    chk("t4_err_pulses", 64'(err_cnt - e0), 2);
    chk("t4_no_writes", 64'(wlog.size()), 0);
    chk("t4_busy", busy, 0);
    chk("t4_finished_kept", finished_loading, 1);
    do_start(3'd2, 3'd3, 1'b1);
    run(2, -1, -1);
    chk("t4_count", 64'(wlog.size()), 6);
    do_start(3'd3, 3'd4, 1'b0);
    run(0, 5, -1);
    chk("t5_restart_count", 64'(wlog.size()), 12);
    chk_w("t5_w11", 11, 2, 3);
    do_start(3'd3, 3'd4, 1'b0);
    run(0, -1, 7);
    chk("t5_rst_count", 64'(wlog.size()), 7);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_write_ready", write_ready, 0);
    chk("t5_rst_finished", finished_loading, 0);
    do_start(3'd2, 3'd2, 1'b0);
    run(0, -1, -1);
    chk("t5_2x2_count", 64'(wlog.size()), 4);
    chk_w("t5_w0", 0, 0, 0);
    chk_w("t5_w3", 3, 1, 1);
    do_start(3'd1, 3'd1, 1'b0);
    run(0, -1, -1);
    chk("t6_count", 64'(wlog.size()), 1);
    chk_w("t6_w0", 0, 0, 0);
    repeat (5) tick;
    chk("t6_finished_hold", finished_loading, 1);
    do_start(3'd2, 3'd5, 1'b1);
    chk("t6_finished_clear", finished_loading, 0);
    run(2, -1, -1);
    chk("t6_next_count", 64'(wlog.size()), 10);
    repeat (6) begin
      r = $urandom_range(1, 4);
      c = $urandom_range(1, 5);
      do_start(3'(r), 3'(c), 1'($urandom % 2));
      run(2, -1, -1);
      chk("rand_count", 64'(wlog.size()), 64'(r * c));
    end
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
